// File: rtl/ts_pkg.sv
// rtl/ts_pkg.sv - shared constants and FSM encoding for the TS packet synchroniser
// Purpose: default sync byte, packet length and the three-state sync FSM encoding.
// Ports: none (package).
package ts_pkg;

   localparam int         PKT_LEN   = 188;
   localparam logic [7:0] SYNC_BYTE = 8'h47;

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous active-low clear
// Purpose: counts inc pulses, sticks at all-ones instead of wrapping.
// Ports:
//   clk    rising-edge clock
//   clr_n  synchronous active-low clear
//   inc    increment request
//   count  current count
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {WIDTH{1'b1}})) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/ts_packet_sync.sv
// rtl/ts_packet_sync.sv - MPEG-TS packet synchroniser with hunt/verify/lock FSM
// Purpose: finds the sync byte at PKT_LEN spacing, locks after LOCK_THRESH hits,
//          flywheels over isolated misses and drops lock after UNLOCK_THRESH misses.
// Ports:
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   valid          byte_data qualifier
//   byte_data      incoming TS byte stream
//   out_data       aligned byte (1-cycle latency)
//   out_valid      out_data qualifier
//   out_sop        output byte is packet byte 0
//   out_eop        output byte is packet byte PKT_LEN-1
//   locked         registered lock status
//   sync_err       one-cycle pulse on a missed sync while locked
//   sync_loss_cnt  saturating count of lock losses
module ts_packet_sync #(
   parameter int                    DATA_WIDTH    = 8,
   parameter int                    PKT_LEN       = ts_pkg::PKT_LEN,
   parameter logic [DATA_WIDTH-1:0] SYNC_BYTE     = DATA_WIDTH'(ts_pkg::SYNC_BYTE),
   parameter int                    LOCK_THRESH   = 3,
   parameter int                    UNLOCK_THRESH = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid,
   input  logic [DATA_WIDTH-1:0] byte_data,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   output logic                  out_sop,
   output logic                  out_eop,
   output logic                  locked,
   output logic                  sync_err,
   output logic [15:0]           sync_loss_cnt
);

   import ts_pkg::*;

   localparam logic [7:0] LAST_IDX = 8'(PKT_LEN - 1);
   localparam logic [7:0] LOCK_T   = 8'(LOCK_THRESH);
   localparam logic [7:0] UNLOCK_T = 8'(UNLOCK_THRESH);

   state_t                state_q,     state_d;
   logic [7:0]            byte_idx_q,  byte_idx_d;
   logic [7:0]            good_cnt_q,  good_cnt_d;
   logic [7:0]            miss_cnt_q,  miss_cnt_d;
   logic [DATA_WIDTH-1:0] out_data_q,  out_data_d;
   logic                  out_valid_q, out_valid_d;
   logic                  out_sop_q,   out_sop_d;
   logic                  out_eop_q,   out_eop_d;
   logic                  locked_q,    locked_d;
   logic                  sync_err_q,  sync_err_d;

   logic                  is_sync;
   logic                  at_sync_pos;
   logic [7:0]            idx_next;
   logic [7:0]            good_inc;
   logic [7:0]            miss_inc;
   logic                  emit;
   logic                  loss_inc;

   always_comb begin
      state_d     = state_q;
      byte_idx_d  = byte_idx_q;
      good_cnt_d  = good_cnt_q;
      miss_cnt_d  = miss_cnt_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
      out_sop_d   = 1'b0;
      out_eop_d   = 1'b0;
      sync_err_d  = 1'b0;
      emit        = 1'b0;
      loss_inc    = 1'b0;

      is_sync     = (byte_data == SYNC_BYTE);
      at_sync_pos = (byte_idx_q == 8'd0);
      idx_next    = (byte_idx_q == LAST_IDX) ? 8'd0 : byte_idx_q + 8'd1;
      good_inc    = good_cnt_q + 8'd1;
      miss_inc    = miss_cnt_q + 8'd1;

      if (valid) begin
         case (state_q)
            HUNT: begin
               // Any sync-valued byte is a candidate; the byte itself is position 0.
               if (is_sync) begin
                  state_d    = VERIFY;
                  byte_idx_d = 8'd1;
                  good_cnt_d = 8'd1;
               end
            end
            VERIFY: begin
               byte_idx_d = idx_next;
               if (at_sync_pos) begin
                  if (is_sync) begin
                     good_cnt_d = good_inc;
                     if (good_inc >= LOCK_T) begin
                        state_d    = LOCKED;
                        miss_cnt_d = 8'd0;
                        emit       = 1'b1;
                     end
                  end else begin
                     // Failed candidate: this byte is consumed, hunting restarts on the next one.
                     state_d    = HUNT;
                     byte_idx_d = 8'd0;
                     good_cnt_d = 8'd0;
                  end
               end
            end
            LOCKED: begin
               byte_idx_d = idx_next;
               emit       = 1'b1;
               if (at_sync_pos) begin
                  if (is_sync) begin
                     miss_cnt_d = 8'd0;
                  end else begin
                     sync_err_d = 1'b1;
                     if (miss_inc >= UNLOCK_T) begin
                        state_d    = HUNT;
                        byte_idx_d = 8'd0;
                        good_cnt_d = 8'd0;
                        miss_cnt_d = 8'd0;
                        loss_inc   = 1'b1;
                        emit       = 1'b0;
                     end else begin
                        miss_cnt_d = miss_inc;
                     end
                  end
               end
            end
            default: begin
               state_d = HUNT;
            end
         endcase
      end

      if (emit) begin
         out_valid_d = 1'b1;
         out_data_d  = byte_data;
         out_sop_d   = at_sync_pos;
         out_eop_d   = (byte_idx_q == LAST_IDX);
      end

      // Tracking the next state lets locked rise together with the lock byte's out_valid.
      locked_d = (state_d == LOCKED);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= HUNT;
         byte_idx_q  <= 8'd0;
         good_cnt_q  <= 8'd0;
         miss_cnt_q  <= 8'd0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_sop_q   <= 1'b0;
         out_eop_q   <= 1'b0;
         locked_q    <= 1'b0;
         sync_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         byte_idx_q  <= byte_idx_d;
         good_cnt_q  <= good_cnt_d;
         miss_cnt_q  <= miss_cnt_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_sop_q   <= out_sop_d;
         out_eop_q   <= out_eop_d;
         locked_q    <= locked_d;
         sync_err_q  <= sync_err_d;
      end
   end

   sat_counter #(
      .WIDTH (16)
   ) u_loss_cnt (
      .clk   (clk),
      .clr_n (rst_n),
      .inc   (loss_inc),
      .count (sync_loss_cnt)
   );

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_sop   = out_sop_q;
   assign out_eop   = out_eop_q;
   assign locked    = locked_q;
   assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_ts_packet_sync.sv
// tb/tb_ts_packet_sync.sv - directed table-driven bench for ts_packet_sync
// Purpose: drives hand-built byte streams and compares every output cycle.
// Ports: none (top-level bench).
module tb_ts_packet_sync;

   localparam int M_IDLE = 0;   // packet not output, not locked
   localparam int M_LOCK = 1;   // packet fully output while locked
   localparam int M_ACQ  = 2;   // packet whose sync byte completes lock
   localparam int M_DROP = 3;   // packet whose sync miss drops lock

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid;
   logic [7:0]  byte_data;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_sop;
   logic        out_eop;
   logic        locked;
   logic        sync_err;
   logic [15:0] sync_loss_cnt;

   int n_checks = 0;
   int n_fail   = 0;
   int nvalid;
   int neop;

   typedef struct {
      logic        rst_n;
      logic        valid;
      logic [7:0]  din;
      logic        ev;
      logic        esop;
      logic        eeop;
      logic        elk;
      logic        eerr;
      logic        cd;
      logic [7:0]  edata;
      logic [15:0] eloss;
   } vec_t;

   vec_t tv[$];

   ts_packet_sync dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .valid         (valid),
      .byte_data     (byte_data),
      .out_data      (out_data),
      .out_valid     (out_valid),
      .out_sop       (out_sop),
      .out_eop       (out_eop),
      .locked        (locked),
      .sync_err      (sync_err),
      .sync_loss_cnt (sync_loss_cnt)
   );

   always #5 clk = ~clk;

   // Payload values stay in 1..64 so they never alias the sync byte.
   function automatic logic [7:0] pkt_byte(input int j);
      if (j == 0) return 8'h47;
      return 8'((j % 64) + 1);
   endfunction

   task automatic push_rst();
      vec_t v;
      v.rst_n = 1'b0; v.valid = 1'b1; v.din = 8'h47;
      v.ev = 1'b0; v.esop = 1'b0; v.eeop = 1'b0; v.elk = 1'b0; v.eerr = 1'b0;
      v.cd = 1'b1; v.edata = 8'h00; v.eloss = 16'd0;
      tv.push_back(v);
   endtask

   task automatic push_byte(input logic [7:0] d, input bit out, input bit sop, input bit eop,
                            input bit lk, input bit err, input logic [15:0] loss, input bit gaps);
      vec_t v;
      vec_t g;
      v.rst_n = 1'b1; v.valid = 1'b1; v.din = d;
      v.ev = out; v.esop = sop; v.eeop = eop; v.elk = lk; v.eerr = err;
      v.cd = out; v.edata = d; v.eloss = loss;
      tv.push_back(v);
      if (gaps) begin
         g = v;
         g.valid = 1'b0; g.din = 8'h47;
         g.ev = 1'b0; g.esop = 1'b0; g.eeop = 1'b0; g.eerr = 1'b0; g.cd = 1'b0;
         tv.push_back(g);
      end
   endtask

   task automatic push_pkt(input bit corrupt, input int mode, input logic [15:0] loss,
                           input bit gaps, input int lo, input int hi);
      logic [7:0] d;
      bit         out;
      bit         err;
      for (int j = lo; j <= hi; j++) begin
         d   = (j == 0 && corrupt) ? 8'h00 : pkt_byte(j);
         out = (mode == M_LOCK) || (mode == M_ACQ);
         err = (j == 0) && corrupt && ((mode == M_LOCK) || (mode == M_DROP));
         push_byte(d, out, out && (j == 0), out && (j == 187), out, err, loss, gaps);
      end
   endtask

   task automatic run_table(input string name);
      bit ok;
      nvalid = 0;
      neop   = 0;
      for (int i = 0; i < tv.size(); i++) begin
         @(negedge clk);
         rst_n     = tv[i].rst_n;
         valid     = tv[i].valid;
         byte_data = tv[i].din;
         @(posedge clk);
         #1;
         ok = (out_valid === tv[i].ev) && (out_sop === tv[i].esop) &&
              (out_eop === tv[i].eeop) && (locked === tv[i].elk) &&
              (sync_err === tv[i].eerr) && (sync_loss_cnt === tv[i].eloss) &&
              (!tv[i].cd || (out_data === tv[i].edata));
         n_checks++;
         if (!ok) begin
            n_fail++;
            $display("FAIL %s[%0d]: got v=%b sop=%b eop=%b lk=%b err=%b loss=%0d data=%h, want v=%b sop=%b eop=%b lk=%b err=%b loss=%0d data=%h",
                     name, i, out_valid, out_sop, out_eop, locked, sync_err, sync_loss_cnt, out_data,
                     tv[i].ev, tv[i].esop, tv[i].eeop, tv[i].elk, tv[i].eerr, tv[i].eloss, tv[i].edata);
         end
         if (out_valid === 1'b1) nvalid++;
         if (out_eop === 1'b1) neop++;
      end
      tv.delete();
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      valid     = 1'b0;
      byte_data = 8'h00;

      // Clean stream, continuous valid: lock on packet 3.
      push_rst();
      push_rst();
      push_pkt(0, M_IDLE, 16'd0, 0, 0, 187);
      push_pkt(0, M_IDLE, 16'd0, 0, 0, 187);
      push_pkt(0, M_ACQ,  16'd0, 0, 0, 187);
      push_pkt(0, M_LOCK, 16'd0, 0, 0, 187);
      run_table("clean");
      check_int("clean_bytes_out", nvalid, 376);
      check_int("clean_eop_count", neop, 2);

      // Same stream with a gap after every byte.
      push_rst();
      push_pkt(0, M_IDLE, 16'd0, 1, 0, 187);
      push_pkt(0, M_IDLE, 16'd0, 1, 0, 187);
      push_pkt(0, M_ACQ,  16'd0, 1, 0, 187);
      push_pkt(0, M_LOCK, 16'd0, 1, 0, 187);
      run_table("gapped");
      check_int("gapped_bytes_out", nvalid, 376);
      check_int("gapped_eop_count", neop, 2);

      // Single flywheel miss, then three consecutive misses and relock.
      push_rst();
      push_pkt(0, M_IDLE, 16'd0, 0, 0, 187);
      push_pkt(0, M_IDLE, 16'd0, 0, 0, 187);
      push_pkt(0, M_ACQ,  16'd0, 0, 0, 187);
      push_pkt(1, M_LOCK, 16'd0, 0, 0, 187);
      push_pkt(0, M_LOCK, 16'd0, 0, 0, 187);
      push_pkt(1, M_LOCK, 16'd0, 0, 0, 187);
      push_pkt(1, M_LOCK, 16'd0, 0, 0, 187);
      push_pkt(1, M_DROP, 16'd1, 0, 0, 187);
      push_pkt(0, M_IDLE, 16'd1, 0, 0, 187);
      push_pkt(0, M_IDLE, 16'd1, 0, 0, 187);
      push_pkt(0, M_ACQ,  16'd1, 0, 0, 187);
      push_pkt(0, M_LOCK, 16'd1, 0, 0, 9);
      run_table("flywheel");
      check_int("flywheel_bytes_out", nvalid, 1138);

      // Garbage with a false sync at offset 10, clean packets from offset 50,
      // then a reset at byte 100 of a locked packet and a fresh acquisition.
      push_rst();
      for (int i = 0; i < 50; i++) begin
         push_byte((i == 10) ? 8'h47 : 8'((i % 64) + 1), 0, 0, 0, 0, 0, 16'd0, 0);
      end
      push_pkt(0, M_IDLE, 16'd0, 0, 0, 187);
      push_pkt(0, M_IDLE, 16'd0, 0, 0, 187);
      push_pkt(0, M_IDLE, 16'd0, 0, 0, 187);
      push_pkt(0, M_ACQ,  16'd0, 0, 0, 187);
      push_pkt(0, M_LOCK, 16'd0, 0, 0, 99);
      push_rst();
      push_pkt(0, M_IDLE, 16'd0, 0, 101, 187);
      push_pkt(0, M_IDLE, 16'd0, 0, 0, 187);
      push_pkt(0, M_IDLE, 16'd0, 0, 0, 187);
      push_pkt(0, M_ACQ,  16'd0, 0, 0, 187);
      push_pkt(0, M_LOCK, 16'd0, 0, 0, 187);
      run_table("resync");
      check_int("resync_bytes_out", nvalid, 664);
      check_int("resync_eop_count", neop, 3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
